// File: rtl/gpu_filter_pkg.sv
// Shared types for the GPU pixel filter core: filter modes and sequencer states.
package gpu_filter_pkg;

    typedef enum logic [1:0] {
        ModePass   = 2'd0,
        ModeInvert = 2'd1,
        ModeThresh = 2'd2,
        ModeBright = 2'd3
    } filt_mode_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdReq  = 3'd1,
        StRdWait = 3'd2,
        StWrReq  = 3'd3,
        StDone   = 3'd4
    } fsm_state_e;

    function automatic logic state_is_busy(input fsm_state_e s);
        return (s == StRdReq) || (s == StRdWait) || (s == StWrReq);
    endfunction

endpackage

// File: rtl/gpu_filter_lane.sv
// Combinational per-pixel filter: pass, invert, threshold or saturating brighten.
module gpu_filter_lane
    import gpu_filter_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  filt_mode_e       mode_i,
    input  logic [PIX_W-1:0] param_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [PIX_W-1:0] pix_o
);

    localparam logic [PIX_W-1:0] MaxPix = {PIX_W{1'b1}};

    // One extra bit so the brighten sum can be tested for overflow.
    logic [PIX_W:0] sum;

    always_comb begin
        sum   = {1'b0, pix_i} + {1'b0, param_i};
        pix_o = pix_i;
        case (mode_i)
            ModePass:   pix_o = pix_i;
            ModeInvert: pix_o = MaxPix - pix_i;
            ModeThresh: pix_o = (pix_i >= param_i) ? MaxPix : '0;
            ModeBright: pix_o = sum[PIX_W] ? MaxPix : sum[PIX_W-1:0];
            default:    pix_o = pix_i;
        endcase
    end

endmodule

// File: rtl/gpu_filter_core.sv
// Word-at-a-time memory-to-memory pixel filter: read a word, filter each lane, write it back.
module gpu_filter_core
    import gpu_filter_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [PIX_W-1:0]         param,
    input  logic [ADDR_W-1:0]        src_adr,
    input  logic [ADDR_W-1:0]        dst_adr,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         words_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_adr,
    output logic [PIX_W*LANES-1:0]   mem_wdata,
    input  logic                     mem_gnt,
    input  logic [PIX_W*LANES-1:0]   mem_rdata,
    input  logic                     mem_rvalid
);

    localparam int unsigned DATA_W    = PIX_W * LANES;
    localparam int unsigned WordBytes = DATA_W / 8;
    localparam int unsigned OffW      = ADDR_W + LEN_W;

    // Byte address of word idx from base; the sum wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_adr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  idx);
        logic [OffW-1:0] off;
        off = OffW'(idx) * OffW'(WordBytes);
        return base + off[ADDR_W-1:0];
    endfunction

    fsm_state_e          state_q, state_d;
    filt_mode_e          mode_q, mode_d;
    logic [PIX_W-1:0]    param_q, param_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    words_done_q, words_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LEN_W-1:0]    wd_inc;
    logic [DATA_W-1:0]   filtered;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gpu_filter_lane #(
            .PIX_W(PIX_W)
        ) u_lane (
            .mode_i (mode_q),
            .param_i(param_q),
            .pix_i  (mem_rdata[k*PIX_W +: PIX_W]),
            .pix_o  (filtered[k*PIX_W +: PIX_W])
        );
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        param_d      = param_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        wd_inc       = words_done_q + LEN_W'(1);

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d       = filt_mode_e'(mode);
                    param_d      = param;
                    src_d        = src_adr;
                    dst_d        = dst_adr;
                    len_d        = len;
                    words_done_d = '0;
                    mem_adr_d    = src_adr;
                    state_d      = (len == '0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                if (mem_gnt) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    mem_wdata_d = filtered;
                    mem_adr_d   = word_adr(dst_q, words_done_q);
                    state_d     = StWrReq;
                end
            end
            StWrReq: begin
                if (mem_gnt) begin
                    words_done_d = wd_inc;
                    mem_adr_d    = word_adr(src_q, wd_inc);
                    state_d      = (wd_inc == len_q) ? StDone : StRdReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        busy_d    = state_is_busy(state_d);
        done_d    = (state_d == StDone);
        mem_req_d = (state_d == StRdReq) || (state_d == StWrReq);
        mem_we_d  = (state_d == StWrReq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mode_q       <= ModePass;
            param_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            param_q      <= param_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_adr    = mem_adr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_gpu_filter_core.sv
// Self-checking bench for gpu_filter_core: a 4-lane instance and a 1-lane instance for address wrap.
module tb_gpu_filter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, sel;
    logic [1:0]  mode;
    logic [7:0]  param;
    logic [31:0] src_adr, dst_adr;
    logic [15:0] len;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        busy0, done0, req0, we0;
    logic [31:0] adr0, wdata0;
    logic [15:0] wd0;
    logic        busy1, done1, req1, we1;
    logic [31:0] adr1;
    logic [7:0]  wdata1;
    logic [15:0] wd1;

    gpu_filter_core u_dut (
        .clk(clk), .reset(reset), .start(start & ~sel), .mode(mode), .param(param),
        .src_adr(src_adr), .dst_adr(dst_adr), .len(len), .busy(busy0), .done(done0),
        .words_done(wd0), .mem_req(req0), .mem_we(we0), .mem_adr(adr0), .mem_wdata(wdata0),
        .mem_gnt(gnt & ~sel), .mem_rdata(rdata), .mem_rvalid(rvalid & ~sel)
    );

    gpu_filter_core #(.PIX_W(8), .LANES(1), .ADDR_W(32), .LEN_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start & sel), .mode(mode), .param(param),
        .src_adr(src_adr), .dst_adr(dst_adr), .len(len), .busy(busy1), .done(done1),
        .words_done(wd1), .mem_req(req1), .mem_we(we1), .mem_adr(adr1), .mem_wdata(wdata1),
        .mem_gnt(gnt & sel), .mem_rdata(rdata[7:0]), .mem_rvalid(rvalid & sel)
    );

    logic        m_busy, m_done, m_req, m_we;
    logic [31:0] m_adr, m_wdata;
    logic [15:0] m_wd;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_done  = sel ? done1 : done0;
    assign m_req   = sel ? req1 : req0;
    assign m_we    = sel ? we1 : we0;
    assign m_adr   = sel ? adr1 : adr0;
    assign m_wdata = sel ? {24'h0, wdata1} : wdata0;
    assign m_wd    = sel ? wd1 : wd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sparse memory; untouched addresses read back as an address hash.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_word(input int md, input int prm, input logic [31:0] w,
                                             input int lanes);
        logic [31:0] r;
        int p, q;
        r = 32'h0;
        for (int k = 0; k < lanes; k++) begin
            p = int'((w >> (8 * k)) & 32'hFF);
            case (md)
                0:       q = p;
                1:       q = 255 - p;
                2:       q = (p >= prm) ? 255 : 0;
                default: q = (p + prm > 255) ? 255 : p + prm;
            endcase
            r = r | (32'(q) << (8 * k));
        end
        return r;
    endfunction

    int          gdly_cfg = 0;
    int          rvlat_cfg = 1;
    bit          spur_cfg = 1'b0;
    int          wait_cnt = 0;
    bit          rv_pend = 1'b0;
    int          rv_cnt = 0;
    logic [31:0] rv_data;
    int          done_cnt = 0;
    logic        hold_we;
    logic [31:0] hold_adr, hold_wdata;
    logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];

    // Memory responder: grant after gdly_cfg cycles, return read data rvlat_cfg cycles later.
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (m_done) done_cnt++;
            rvalid = 1'b0;
            rdata  = $urandom;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    rvalid = 1'b1; rdata = rv_data; rv_pend = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (spur_cfg && ($urandom_range(0, 3) == 0)) begin
                rvalid = 1'b1;
            end
            gnt = 1'b0;
            if (m_req) begin
                if (wait_cnt > 0) begin
                    chk("req_hold_we", 32'(m_we), 32'(hold_we));
                    chk("req_hold_adr", m_adr, hold_adr);
                    if (m_we) chk("req_hold_wdata", m_wdata, hold_wdata);
                end
                hold_we = m_we; hold_adr = m_adr; hold_wdata = m_wdata;
                if (wait_cnt < gdly_cfg) begin
                    wait_cnt++;
                end else begin
                    gnt = 1'b1;
                    wait_cnt = 0;
                    if (m_we) begin
                        wr_adr_q.push_back(m_adr);
                        wr_dat_q.push_back(m_wdata);
                        mem[m_adr] = m_wdata;
                    end else begin
                        rd_adr_q.push_back(m_adr);
                        rv_pend = 1'b1;
                        rv_cnt  = rvlat_cfg - 1;
                        rv_data = rd_word(m_adr);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(m_busy), 32'h0);
        chk({tag, "_done"}, 32'(m_done), 32'h0);
        chk({tag, "_req"}, 32'(m_req), 32'h0);
        chk({tag, "_we"}, 32'(m_we), 32'h0);
        chk({tag, "_adr"}, m_adr, 32'h0);
        chk({tag, "_wdata"}, m_wdata, 32'h0);
        chk({tag, "_words_done"}, 32'(m_wd), 32'h0);
    endtask

    task automatic run_job(input bit s, input int md, input logic [7:0] prm,
                           input logic [31:0] src, input logic [31:0] dst, input int n,
                           input int gd, input int rl, input bit spur, input bit poke);
        logic [31:0] ov [logic [31:0]];
        logic [31:0] exp_adr[$], exp_dat[$], exp_rd[$];
        logic [31:0] ra, wa, w;
        int bytes, lanes, cyc;
        bytes = s ? 1 : 4;
        lanes = s ? 1 : 4;
        // Reference: strictly sequential read-then-write of each word, ascending.
        for (int i = 0; i < n; i++) begin
            ra = src + 32'(i * bytes);
            wa = dst + 32'(i * bytes);
            w  = ov.exists(ra) ? ov[ra] : rd_word(ra);
            if (s) w = w & 32'hFF;
            exp_rd.push_back(ra);
            exp_adr.push_back(wa);
            exp_dat.push_back(ref_word(md, int'(prm), w, lanes));
            ov[wa] = ref_word(md, int'(prm), w, lanes);
        end
        @(negedge clk);
        sel = s; gdly_cfg = gd; rvlat_cfg = rl; spur_cfg = spur;
        wr_adr_q.delete(); wr_dat_q.delete(); rd_adr_q.delete();
        done_cnt = 0;
        mode = 2'(md); param = prm; src_adr = src; dst_adr = dst; len = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); param = 8'($urandom); src_adr = $urandom; dst_adr = $urandom;
        len = 16'($urandom);
        cyc = 0;
        while (!m_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (poke && m_busy && (cyc % 7 == 3)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("job_done_seen", 32'(m_done), 32'h1);
        chk("busy_in_done", 32'(m_busy), 32'h0);
        repeat (4) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'h1);
        chk("words_done", 32'(m_wd), 32'(n));
        chk("idle_req", 32'(m_req), 32'h0);
        chk("write_count", 32'(wr_adr_q.size()), 32'(n));
        chk("read_count", 32'(rd_adr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_adr_q.size()) begin
                chk("wr_adr", wr_adr_q[i], exp_adr[i]);
                chk("wr_data", wr_dat_q[i], exp_dat[i]);
            end
            if (i < rd_adr_q.size()) chk("rd_adr", rd_adr_q[i], exp_rd[i]);
        end
    endtask

    typedef struct packed {
        logic [1:0]  md;
        logic [7:0]  prm;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; sel = 1'b0; mode = 2'd0; param = 8'h0;
        src_adr = 32'h0; dst_adr = 32'h0; len = 16'h0;

        vecs[0] = '{2'd1, 8'h00, 32'h00FF_7F10, 32'hFF00_80EF};
        vecs[1] = '{2'd3, 8'h20, 32'hF0E0_1000, 32'hFFFF_3020};
        vecs[2] = '{2'd2, 8'h80, 32'h807F_0001, 32'hFF00_0000};
        vecs[3] = '{2'd0, 8'h5A, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{2'd3, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{2'd2, 8'h00, 32'h0001_7F00, 32'hFFFF_FFFF};
        vecs[6] = '{2'd2, 8'hFF, 32'hFFFE_0100, 32'hFF00_0000};
        vecs[7] = '{2'd3, 8'h01, 32'hFEFF_0001, 32'hFFFF_0102};

        repeat (3) @(negedge clk);
        chk_idle("reset0");
        sel = 1'b1;
        #1 chk_idle("reset1");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mem[32'h400] = vecs[i].word;
            run_job(1'b0, int'(vecs[i].md), vecs[i].prm, 32'h400, 32'h500, 1, i % 3, 1 + i % 2,
                    i[0], 1'b0);
            chk("vec_wdata", (wr_dat_q.size() > 0) ? wr_dat_q[0] : 32'hDEAD_BEEF, vecs[i].exp);
        end

        // Two-word invert job.
        mem[32'h100] = 32'h00FF_7F10;
        mem[32'h104] = 32'h8040_2001;
        run_job(1'b0, 1, 8'h00, 32'h100, 32'h200, 2, 0, 2, 1'b0, 1'b0);
        chk("inv_adr0", (wr_adr_q.size() > 0) ? wr_adr_q[0] : 32'hX, 32'h200);
        chk("inv_dat0", (wr_dat_q.size() > 0) ? wr_dat_q[0] : 32'hX, 32'hFF00_80EF);
        chk("inv_adr1", (wr_adr_q.size() > 1) ? wr_adr_q[1] : 32'hX, 32'h204);
        chk("inv_dat1", (wr_dat_q.size() > 1) ? wr_dat_q[1] : 32'hX, 32'h7FBF_DFFE);
        repeat (10) @(negedge clk);
        chk("words_done_hold", 32'(m_wd), 32'h2);

        // len = 0: done on the cycle after start, no memory traffic, words_done cleared.
        done_cnt = 0;
        mode = 2'd2; param = 8'h80; len = 16'h0; src_adr = 32'h100; dst_adr = 32'h200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(m_done), 32'h1);
        chk("len0_req", 32'(m_req), 32'h0);
        chk("len0_busy", 32'(m_busy), 32'h0);
        chk("len0_words_done", 32'(m_wd), 32'h0);
        @(negedge clk);
        chk("len0_done_low", 32'(m_done), 32'h0);
        chk("len0_req_low", 32'(m_req), 32'h0);

        // Stalled grants plus start pulses while busy.
        run_job(1'b0, 2, 8'h80, 32'h600, 32'h700, 3, 5, 2, 1'b1, 1'b1);

        // Reset while a read is outstanding; its late rvalid must be ignored.
        gdly_cfg = 0; rvlat_cfg = 8; spur_cfg = 1'b0;
        wr_adr_q.delete(); rd_adr_q.delete();
        mode = 2'd1; param = 8'h0; src_adr = 32'h800; dst_adr = 32'h900; len = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_adr_q.size() == 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_read_granted", 32'(rd_adr_q.size()), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            chk_idle("after_reset");
            @(negedge clk);
        end
        chk("rst_no_write", 32'(wr_adr_q.size()), 32'h0);
        chk("rst_no_done", 32'(done_cnt), 32'h0);
        chk("rst_rvalid_drained", 32'(rv_pend), 32'h0);

        // Overlapping source and destination in both directions.
        run_job(1'b0, 3, 8'h11, 32'h300, 32'h304, 4, 1, 1, 1'b1, 1'b0);
        run_job(1'b0, 1, 8'h00, 32'h344, 32'h340, 4, 0, 3, 1'b0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            run_job(1'b0, $urandom_range(0, 3), 8'($urandom),
                    32'h1000 + 32'($urandom_range(0, 31) * 4),
                    32'h1000 + 32'($urandom_range(0, 31) * 4),
                    $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(1, 3),
                    1'($urandom), 1'($urandom));
        end

        // Single-lane instance: byte-sized words wrapping through address 0.
        run_job(1'b1, 3, 8'h40, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 5, 1, 1, 1'b1, 1'b0);
        chk("wrap_rd_adr2", (rd_adr_q.size() > 2) ? rd_adr_q[2] : 32'hX, 32'h0);
        chk("wrap_wr_adr4", (wr_adr_q.size() > 4) ? wr_adr_q[4] : 32'hX, 32'h0);
        for (int j = 0; j < 4; j++) begin
            run_job(1'b1, $urandom_range(0, 3), 8'($urandom), 32'hFFFF_FFF0 + 32'(j * 3),
                    32'hFFFF_FFF8, $urandom_range(1, 12), $urandom_range(0, 2),
                    $urandom_range(1, 3), 1'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_filter_core.md
GPU_FILTER_CORE -- requirements
Module: gpu_filter_core

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-002 SHALL have parameter LANES, default 4, pixels per memory word; DATA_W = PIX_W*LANES.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter LEN_W, default 16, word-count width.
REQ-005 SHALL have ports, in order (all synchronous to clk):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start.
- mode  in  2  filter select.
- param  in  PIX_W  threshold or brightness offset.
- src_adr  in  ADDR_W  source byte address.
- dst_adr  in  ADDR_W  destination byte address.
- len  in  LEN_W  words to process.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- words_done  out  LEN_W  words written this job.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_adr  out  ADDR_W  request byte address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  mem_rdata valid; arrives no earlier than one cycle after the read grant.

Function
REQ-006 SHALL run an FSM with states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-007 SHALL go from IDLE on start=1:
- latch mode, param, src_adr, dst_adr and len;
- clear words_done;
- enter RD_REQ, or DONE if len=0.
REQ-008 SHALL ignore start in every state other than IDLE; a running job's configuration SHALL never change.
REQ-009 SHALL drive RD_REQ with mem_req=1, mem_we=0 and mem_adr=src+words_done*(DATA_W/8), modulo 2^ADDR_W; it SHALL hold these until mem_gnt=1, then enter RD_WAIT.
REQ-010 SHALL stay in RD_WAIT with mem_req=0; on mem_rvalid=1 it SHALL register the filtered word and enter WR_REQ.
REQ-011 SHALL ignore mem_rvalid in every state other than RD_WAIT.
REQ-012 SHALL drive WR_REQ with mem_req=1, mem_we=1, mem_adr=dst+words_done*(DATA_W/8) and mem_wdata=filtered word; it SHALL hold these until mem_gnt=1.
REQ-013 SHALL, on the WR_REQ grant, increment words_done; it SHALL enter DONE if the new value equals the latched len, else RD_REQ.
REQ-014 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; busy SHALL be 1 in RD_REQ, RD_WAIT and WR_REQ, else 0.
REQ-015 SHALL filter each of the LANES lanes independently, lane k = bits [k*PIX_W +: PIX_W], with MAX = 2^PIX_W-1:
- mode 0: p (pass-through).
- mode 1: MAX-p (invert).
- mode 2: (p >= param) ? MAX : 0 (threshold).
- mode 3: min(p+param, MAX), sum computed at PIX_W+1 bits (saturating brighten).
REQ-016 SHALL keep mem_req=0 in IDLE and DONE; mem_adr and mem_wdata are don't-care whenever mem_req=0.
REQ-017 SHALL allow src and dst ranges to overlap; words SHALL be strictly read-then-written in ascending order.
REQ-018 SHALL keep words_done valid after DONE until the next accepted start.

Reset
REQ-019 SHALL on reset=1 at a clk edge, in any state including mid-transaction:
- enter IDLE;
- drive busy=0, done=0, words_done=0, mem_req=0, mem_we=0;
- clear mem_adr, mem_wdata and all latched configuration to 0.
REQ-020 SHALL not emit a done pulse for a job aborted by reset; a mem_rvalid arriving after reset SHALL be ignored.

Structure
REQ-021 SHALL take the filter mode enum (PASS, INVERT, THRESH, BRIGHT) and the FSM state enum from a shared package, gpu_filter_pkg.
REQ-022 SHALL implement the per-lane filter as one combinational sub-module, gpu_filter_lane, instantiated LANES times by generate.

Verification
REQ-023 SHALL cover: mode 1, len=2, src=0x100, mem word 0x00FF7F10 -> writes 0xFF0080EF to 0x200, then the second word to 0x204; done after two write grants; words_done=2.
REQ-024 SHALL cover: mode 3, param=0x20, word 0xF0E01000 -> 0xFFFF3020 (saturation in lanes 3 and 2).
REQ-025 SHALL cover: mode 2, param=0x80, word 0x807F0001 -> 0xFF000000; len=0 -> done one cycle after start, no mem_req.
REQ-026 SHALL cover: mem_gnt withheld 5 cycles in RD_REQ and WR_REQ, plus a start pulse while busy -> request signals stable, job unchanged, exactly one done.
REQ-027 SHALL cover: reset asserted in RD_WAIT, then a late mem_rvalid -> IDLE, all outputs zero, no write issued, no done.
REQ-028 SHALL cover: PIX_W=8, LANES=1 and src=0xFFFFFFFF-class wrap address -> address wraps modulo 2^ADDR_W, results match the reference model.
